// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter.
//   N_REQ       - number of requesters
//   ID_W        - width of a requester index
//   state_e     - arbiter FSM states
//   next_winner - rotating priority search starting at ptr
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StTurn = 2'd2
  } state_e;

  // First set request bit searching ptr, ptr+1, ... (mod N_REQ).
  // Returns ptr when no bit is set; callers only use it with req != 0.
  function automatic logic [ID_W-1:0] next_winner(input logic [N_REQ-1:0] req,
                                                  input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] idx;
    logic            found;
    next_winner = ptr;
    found       = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        next_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/grant_dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable.
//   idx_i    - winner index
//   en_i     - grant active; all outputs low when 0
//   onehot_o - one-hot grant vector
module grant_dec2to4
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]  idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one resource between four requesters.
// The owner keeps the grant while it requests, for at most MAX_HOLD cycles;
// each grant is followed by a one-cycle TURN gap and an IDLE cycle.
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - permits new grants (does not cut a grant in progress)
//   req       - request vector, bit i = requester i
//   gnt       - registered one-hot grant, zero when no grant is active
//   gnt_id    - index of the current or last winner
//   gnt_valid - high exactly when gnt is non-zero
//   timeout   - one-cycle pulse in TURN after a forced release
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              timeout_q, timeout_d;
  logic              gnt_en;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_id_d   = gnt_id_q;
    timeout_d  = 1'b0;
    gnt_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && (req != '0)) begin
          gnt_id_d   = next_winner(req, ptr_q);
          hold_cnt_d = CNT_W'(1);
          gnt_en     = 1'b1;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (!req[gnt_id_q]) begin
          // A drop on the same edge as the limit is a normal release.
          ptr_d   = gnt_id_q + ID_W'(1);
          state_d = StTurn;
        end else if (hold_cnt_q == MaxHold) begin
          ptr_d     = gnt_id_q + ID_W'(1);
          timeout_d = 1'b1;
          state_d   = StTurn;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
          gnt_en     = 1'b1;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  grant_dec2to4 u_dec (
    .idx_i    (gnt_id_d),
    .en_i     (gnt_en),
    .onehot_o (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_id_q   <= '0;
      gnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule
